// File: rtl/countdown_timer_ctrl_if.sv
// Button/tick inputs and timer status outputs of the countdown timer controller.
// The slave modport is the controller's view; master is the driver side.
interface countdown_timer_ctrl_if;
  logic       tick_1hz;
  logic       btn_add_min;
  logic       btn_add_10s;
  logic       btn_start_stop;
  logic       btn_clear;
  logic [7:0] seconds_total;
  logic       running;
  logic       alarm;
  logic [2:0] state;

  modport master (
    output tick_1hz, btn_add_min, btn_add_10s, btn_start_stop, btn_clear,
    input  seconds_total, running, alarm, state
  );

  modport slave (
    input  tick_1hz, btn_add_min, btn_add_10s, btn_start_stop, btn_clear,
    output seconds_total, running, alarm, state
  );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// Kitchen countdown timer sequencer: button edge detection, saturating time load,
// run/pause/alarm state machine driven by a 1 Hz tick.
module countdown_timer_ctrl #(
  parameter int MAX_SECONDS = 255,
  parameter int ALARM_TICKS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  countdown_timer_ctrl_if.slave bus
);
  localparam int CW = (ALARM_TICKS < 2) ? 1 : $clog2(ALARM_TICKS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_q, state_n;
  logic [7:0]      secs_q, secs_n;
  logic [CW-1:0]   acnt_q, acnt_n, acnt_inc;
  logic [3:0]      prev_q, levels, press;
  logic            clr_p, ss_p, add_p;
  logic [8:0]      sum;
  logic [7:0]      added;

  // Bit order: {clear, start_stop, add_min, add_10s}, also the priority order.
  assign levels = {bus.btn_clear, bus.btn_start_stop, bus.btn_add_min, bus.btn_add_10s};
  assign press  = levels & ~prev_q;
  assign clr_p  = press[3];
  assign ss_p   = ~press[3] & press[2];
  assign add_p  = ~press[3] & ~press[2] & (press[1] | press[0]);

  assign sum      = {1'b0, secs_q} + (press[1] ? 9'd60 : 9'd10);
  assign added    = (sum > 9'(MAX_SECONDS)) ? 8'(MAX_SECONDS) : sum[7:0];
  assign acnt_inc = acnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      secs_q  <= 8'd0;
      acnt_q  <= '0;
      prev_q  <= 4'd0;
    end else begin
      state_q <= state_n;
      secs_q  <= secs_n;
      acnt_q  <= acnt_n;
      prev_q  <= levels;
    end
  end

  always_comb begin
    state_n = state_q;
    secs_n  = secs_q;
    acnt_n  = acnt_q;
    if (clr_p) begin
      state_n = IDLE;
      secs_n  = 8'd0;
      acnt_n  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          secs_n = 8'd0;
          if (add_p) begin
            secs_n = added;
            if (added != 8'd0) state_n = SET;
          end
        end
        SET: begin
          if (ss_p)       state_n = RUN;
          else if (add_p) secs_n  = added;
        end
        RUN: begin
          if (ss_p) begin
            state_n = PAUSE;
          end else if (bus.tick_1hz) begin
            if (secs_q <= 8'd1) begin
              secs_n  = 8'd0;
              state_n = DONE;
              acnt_n  = '0;
            end else begin
              secs_n = secs_q - 8'd1;
            end
          end
        end
        PAUSE: begin
          if (ss_p)       state_n = RUN;
          else if (add_p) secs_n  = added;
        end
        DONE: begin
          secs_n = 8'd0;
          if (ss_p) begin
            state_n = IDLE;
            acnt_n  = '0;
          end else if (bus.tick_1hz) begin
            acnt_n = acnt_inc;
            if (acnt_inc == CW'(ALARM_TICKS)) begin
              state_n = IDLE;
              acnt_n  = '0;
            end
          end
        end
        default: begin
          state_n = IDLE;
          secs_n  = 8'd0;
          acnt_n  = '0;
        end
      endcase
    end
  end

  assign bus.seconds_total = secs_q;
  assign bus.state         = state_q;
  assign bus.running       = (state_q == RUN);
  assign bus.alarm         = (state_q == DONE);
endmodule
